// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: memory word, byte-enable mask, arbiter state
// and the request payload latched by the memory port arbiter.
package lc3b_types;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned MASK_W = 2;

  typedef logic [WORD_W-1:0] lc3b_word;
  typedef logic [MASK_W-1:0] lc3b_mem_mask;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_A = 2'd1,
    BUSY_B = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic         write;
    lc3b_word     addr;
    lc3b_word     wdata;
    lc3b_mem_mask wmask;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Serialises the instruction (A) and data (B) memory ports onto one physical
// memory interface; B has priority, a starvation counter guarantees A progress.
module mem_port_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_a,
  input  logic        mem_write_a,
  input  logic [15:0] mem_address_a,
  input  logic [15:0] mem_wdata_a,
  input  logic [1:0]  mem_wmask_a,
  output logic        mem_resp_a,
  output logic [15:0] mem_rdata_a,
  input  logic        mem_read_b,
  input  logic        mem_write_b,
  input  logic [15:0] mem_address_b,
  input  logic [15:0] mem_wdata_b,
  input  logic [1:0]  mem_wmask_b,
  output logic        mem_resp_b,
  output logic [15:0] mem_rdata_b,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [15:0] pmem_address,
  output logic [15:0] pmem_wdata,
  output logic [1:0]  pmem_wmask,
  input  logic        pmem_resp,
  input  logic [15:0] pmem_rdata
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t       state;
  logic [CNT_W-1:0] starve_cnt;

  mem_req_t req_a_c;
  mem_req_t req_b_c;
  mem_req_t grant_req_c;
  logic     pend_a_c;
  logic     pend_b_c;
  logic     grant_a_c;

  // Arbitration on the current cycle's requests; read+write together is a write.
  always_comb begin
    req_a_c       = '0;
    req_b_c       = '0;
    req_a_c.write = mem_write_a;
    req_a_c.addr  = mem_address_a;
    req_a_c.wdata = mem_wdata_a;
    req_a_c.wmask = mem_wmask_a;
    req_b_c.write = mem_write_b;
    req_b_c.addr  = mem_address_b;
    req_b_c.wdata = mem_wdata_b;
    req_b_c.wmask = mem_wmask_b;
    pend_a_c      = mem_read_a | mem_write_a;
    pend_b_c      = mem_read_b | mem_write_b;
    grant_a_c     = pend_a_c && (!pend_b_c || (starve_cnt >= CNT_LIMIT));
    grant_req_c   = grant_a_c ? req_a_c : req_b_c;
  end

  // Transaction FSM; the pmem_* registers double as the latched request copy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      mem_resp_a   <= 1'b0;
      mem_resp_b   <= 1'b0;
      mem_rdata_a  <= '0;
      mem_rdata_b  <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      pmem_wmask   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pend_a_c || pend_b_c) begin
            pmem_address <= grant_req_c.addr;
            pmem_wdata   <= grant_req_c.wdata;
            pmem_wmask   <= grant_req_c.wmask;
            pmem_write   <= grant_req_c.write;
            pmem_read    <= !grant_req_c.write;
            state        <= grant_a_c ? BUSY_A : BUSY_B;
            if (grant_a_c) begin
              starve_cnt <= '0;
            end else if (pend_a_c && (starve_cnt != CNT_MAX)) begin
              starve_cnt <= starve_cnt + CNT_W'(1);
            end
          end
        end
        BUSY_A, BUSY_B: begin
          if (pmem_resp) begin
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            state      <= DONE;
            if (state == BUSY_A) begin
              mem_resp_a <= 1'b1;
              if (!pmem_write) mem_rdata_a <= pmem_rdata;
            end else begin
              mem_resp_b <= 1'b1;
              if (!pmem_write) mem_rdata_b <= pmem_rdata;
            end
          end
        end
        DONE: begin
          mem_resp_a <= 1'b0;
          mem_resp_b <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Responder for the two pipeline memory ports:
  - Port A: instruction fetch, read-only in practice.
  - Port B: data.
- Serialises both ports onto a single downstream physical-memory interface and returns a one-cycle mem_resp pulse to the port being served.
- Sits between the pipelined datapath and the shared cache/physical memory.
- Port B (older instruction, MEM stage) normally has priority. A starvation counter guarantees forward progress for port A.

Parameters:
- STARVE_LIMIT, 4, number of consecutive arbitration losses by a pending port A before A is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- mem_read_a  in  1  port A read request, level-held until mem_resp_a
- mem_write_a  in  1  port A write request
- mem_address_a  in  16  port A word address (lc3b_word)
- mem_wdata_a  in  16  port A write data
- mem_wmask_a  in  2  port A byte enables, bit0 = low byte
- mem_resp_a  out  1  port A completion pulse
- mem_rdata_a  out  16  port A read data, valid when mem_resp_a = 1
- mem_read_b, mem_write_b, mem_address_b, mem_wdata_b, mem_wmask_b  in  1/1/16/16/2  port B request, same rules as port A
- mem_resp_b  out  1  port B completion pulse
- mem_rdata_b  out  16  port B read data
- pmem_read  out  1  downstream read strobe, held until pmem_resp
- pmem_write  out  1  downstream write strobe, held until pmem_resp
- pmem_address  out  16  downstream address
- pmem_wdata  out  16  downstream write data
- pmem_wmask  out  2  downstream byte enables
- pmem_resp  in  1  downstream completion
- pmem_rdata  in  16  downstream read data, valid with pmem_resp

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0: resp, strobes, address, wdata, wmask, rdata.
  - Starvation counter clears.
- Reset mid-transaction: downstream strobes drop on the next cycle and the transaction is abandoned; no upstream resp is issued.
- States: IDLE, BUSY_A, BUSY_B, DONE.
- IDLE arbitration, combinational on that cycle's requests. A port is "pending" when read or write is asserted.
  - Only A pending: grant A.
  - Only B pending: grant B.
  - Both pending and starve_cnt >= STARVE_LIMIT: grant A.
  - Both pending otherwise: grant B, and increment starve_cnt (saturating).
  - On any grant to A, starve_cnt clears.
  - On grant, latch the granted port's address, wdata, wmask and op type. Go to BUSY_A or BUSY_B.
- Read and write asserted together on one port: treated as a write.
- BUSY_x:
  - pmem_read or pmem_write and the address/data/mask are driven from the latched copy, constant for the whole transaction.
  - On pmem_resp = 1: capture pmem_rdata into the selected port's rdata register and go to DONE.
  - For writes, that port's rdata is left unchanged.
- DONE:
  - mem_resp_x = 1 for exactly this cycle; strobes are 0.
  - The next state is always IDLE.
  - mem_rdata_x holds its value until the next read completion on that port.
- Latency:
  - Request visible in IDLE at cycle 0.
  - pmem strobe from cycle 1.
  - If pmem_resp arrives in cycle k, upstream resp is in cycle k+1.
  - Minimum is 3 cycles with k = 1. Back-to-back transactions are separated by one IDLE cycle.
- Upstream requests are not re-sampled after the grant. A request withdrawn mid-transaction still completes and is still acknowledged.
- A request that is still held after its resp is served again (stalled re-fetch is legal).
- pmem_resp seen in IDLE or DONE is ignored.
- mem_resp_a and mem_resp_b are never asserted in the same cycle.
- pmem_read and pmem_write are never both 1.

Decomposition:
- lc3b_types package:
  - lc3b_word already exists there.
  - Add lc3b_mem_mask (2-bit byte-enable type).
  - Add arb_state_t enum {IDLE, BUSY_A, BUSY_B, DONE}.
- Single module. The starvation counter and request latch are small and stay inline; no sub-module is warranted.

Test Plan:
- Single A read:
  - Stimulus: mem_read_a = 1, address 0x0040; downstream answers pmem_resp with 0x1234 after 2 cycles.
  - Response: pmem_read = 1 with address 0x0040 from cycle 1; mem_resp_a pulses once at cycle 4 with mem_rdata_a = 0x1234; mem_resp_b stays 0.
- B byte write:
  - Stimulus: mem_write_b = 1, address 0x0102, wdata 0xAB00, wmask 2'b10.
  - Response: pmem_write = 1 with identical address/data/mask; one mem_resp_b pulse; mem_rdata_b unchanged.
- Simultaneous requests, STARVE_LIMIT = 4:
  - Stimulus: A and B held continuously, B re-requesting after each resp.
  - Response: grant order is B, B, B, B, A, B...; starve_cnt reaches 4, then clears on A's grant.
- Reset during transaction:
  - Stimulus: rst_n = 0 in BUSY_B while pmem_read = 1.
  - Response: next cycle all outputs are 0 and state is IDLE; no mem_resp_b; a late pmem_resp is ignored.
- Read and write together on A:
  - Stimulus: mem_read_a = mem_write_a = 1.
  - Response: downstream sees pmem_write = 1 and pmem_read = 0.
- Spurious pmem_resp in IDLE:
  - Stimulus: pmem_resp = 1 with no upstream request.
  - Response: no mem_resp_a or mem_resp_b; state stays IDLE.
